// File: rtl/ascon_round_ctrl.sv
// Round sequencer for the Ascon p^12 / p^8 permutation.
// Holds the 320-bit state and steps the external round datapath once per cycle.
module ascon_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         nrounds,
  input  logic [319:0] state_in,
  output logic [3:0]   rnd,
  output logic [319:0] round_out,
  input  logic [319:0] round_in,
  output logic         busy,
  output logic         done,
  output logic [319:0] state_out
);

  localparam int unsigned STATE_W = 320;
  localparam int unsigned RND_W   = 4;

  // Both round counts finish on the same index, so only the start point differs.
  localparam logic [RND_W-1:0] RND_P12  = RND_W'(4'h4);
  localparam logic [RND_W-1:0] RND_P8   = RND_W'(4'h8);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(4'hF);
  localparam logic [RND_W-1:0] RND_IDLE = RND_W'(4'h0);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  fsm_t               fsm;
  logic [STATE_W-1:0] st;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm  <= IDLE;
      st   <= '0;
      rnd  <= RND_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            st   <= state_in;
            rnd  <= nrounds ? RND_P12 : RND_P8;
            busy <= 1'b1;
            fsm  <= RUN;
          end
        end
        RUN: begin
          st <= round_in;
          if (rnd == RND_LAST) begin
            fsm  <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            rnd  <= RND_IDLE;
          end else begin
            rnd <= rnd + RND_W'(1);
          end
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
          rnd  <= RND_IDLE;
        end
      endcase
    end
  end

  assign round_out = st;
  assign state_out = st;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Bench for ascon_round_ctrl: closes the loop with an Ascon round function
// and scoreboards each permutation result against a reference p^n.
module tb_ascon_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         nrounds;
  logic [319:0] state_in;
  logic [3:0]   rnd;
  logic [319:0] round_out;
  logic [319:0] round_in;
  logic         busy;
  logic         done;
  logic [319:0] state_out;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;
  int issue_cyc = 0;
  int done_cyc[$];
  logic [319:0] exp_q[$];

  always #5 clk = ~clk;

  ascon_round_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .nrounds  (nrounds),
    .state_in (state_in),
    .rnd      (rnd),
    .round_out(round_out),
    .round_in (round_in),
    .busy     (busy),
    .done     (done),
    .state_out(state_out)
  );

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round; rnd 4..F maps to round constants 0xf0..0x4b.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [3:0]  i;
    i  = r - 4'h4;
    x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
    x2 = x2 ^ {56'h0, 4'hF - i, i};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int n);
    logic [319:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = ascon_round(v, 4'(16 - n + i));
    return v;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  assign round_in = ascon_round(round_out, rnd);

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_done", 320'(done), 320'(0));
      else chk("result", state_out, exp_q.pop_front());
    end
    if (!rst && !busy) chk("rnd_zero_when_idle", 320'(rnd), 320'(0));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic nr, input logic [319:0] s);
    start     = 1'b1;
    nrounds   = nr;
    state_in  = s;
    exp_q.push_back(perm(s, nr ? 12 : 8));
    issue_cyc = cyc;
    tick();
    start    = 1'b0;
    nrounds  = 1'($urandom);
    state_in = rand320();
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    chk("done_within_bound", 320'(done), 320'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int d0;
    logic [319:0] a, b, snap;
    rst = 1'b1; start = 1'b0; nrounds = 1'b0; state_in = '0;
    tick(); tick();
    chk("reset_busy", 320'(busy), 320'(0));
    chk("reset_done", 320'(done), 320'(0));
    chk("reset_rnd", 320'(rnd), 320'(0));
    chk("reset_state", state_out, 320'(0));
    rst = 1'b0;
    tick();

    // p^12 on the zero state, stepping through every round index
    issue(1'b1, 320'(0));
    chk("p12_busy", 320'(busy), 320'(1));
    chk("p12_rnd_first", 320'(rnd), 320'(4'h4));
    for (int j = 1; j < 12; j++) begin
      tick();
      chk("p12_rnd_seq", 320'(rnd), 320'(4 + j));
      chk("p12_no_early_done", 320'(done), 320'(0));
    end
    tick();
    chk("p12_done", 320'(done), 320'(1));
    chk("p12_busy_low", 320'(busy), 320'(0));
    chk("p12_latency", 320'(done_cyc[$] - issue_cyc), 320'(13));
    chk("p12_rnd_after", 320'(rnd), 320'(0));
    snap = state_out;
    tick();
    chk("p12_done_one_cycle", 320'(done), 320'(0));
    chk("p12_state_holds", state_out, snap);

    // p^8 on a random state
    issue(1'b0, rand320());
    chk("p8_rnd_first", 320'(rnd), 320'(4'h8));
    for (int j = 1; j < 8; j++) begin
      tick();
      chk("p8_rnd_seq", 320'(rnd), 320'(8 + j));
    end
    tick();
    chk("p8_done", 320'(done), 320'(1));
    chk("p8_latency", 320'(done_cyc[$] - issue_cyc), 320'(9));
    tick();

    // start while busy is ignored
    a = rand320();
    b = rand320();
    issue(1'b1, a);
    repeat (5) tick();
    chk("busy_start_rnd9", 320'(rnd), 320'(4'h9));
    start = 1'b1; nrounds = 1'b0; state_in = b;
    tick();
    start = 1'b0;
    chk("busy_start_ignored_rnd", 320'(rnd), 320'(4'hA));
    d0 = done_cnt;
    wait_done(20, n);
    chk("busy_start_remaining", 320'(n), 320'(6));
    repeat (3) tick();
    chk("busy_start_single_done", 320'(done_cnt), 320'(d0 + 1));
    chk("busy_start_idle", 320'(busy), 320'(0));

    // back-to-back: start in the done cycle with nrounds toggled
    issue(1'b1, rand320());
    wait_done(20, n);
    chk("b2b_first_latency", 320'(n), 320'(12));
    chk("b2b_first_issue_to_done", 320'(done_cyc[$] - issue_cyc), 320'(13));
    a = rand320();
    issue(1'b0, a);
    chk("b2b_busy", 320'(busy), 320'(1));
    chk("b2b_rnd", 320'(rnd), 320'(4'h8));
    chk("b2b_state_loaded", state_out, a);
    wait_done(20, n);
    chk("b2b_second_latency", 320'(n), 320'(8));
    chk("b2b_done_spacing", 320'(done_cyc[$] - done_cyc[$-1]), 320'(9));
    tick();

    // reset mid-run together with start
    issue(1'b1, rand320());
    repeat (3) tick();
    chk("rst_rnd7", 320'(rnd), 320'(4'h7));
    rst = 1'b1; start = 1'b1; state_in = rand320();
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", 320'(busy), 320'(0));
    chk("rst_done", 320'(done), 320'(0));
    chk("rst_rnd", 320'(rnd), 320'(0));
    chk("rst_state", state_out, 320'(0));
    exp_q.delete();
    d0 = done_cnt;
    repeat (16) tick();
    chk("rst_no_done", 320'(done_cnt), 320'(d0));

    // start held through reset is taken on the first edge with rst low
    a = rand320();
    rst = 1'b1; start = 1'b1; nrounds = 1'b0; state_in = a;
    tick();
    chk("rst_priority", 320'(busy), 320'(0));
    rst = 1'b0;
    issue(1'b0, a);
    chk("post_rst_accept", 320'(busy), 320'(1));
    chk("post_rst_rnd", 320'(rnd), 320'(4'h8));
    wait_done(20, n);
    chk("post_rst_latency", 320'(n), 320'(8));
    tick();

    // idle for 20 cycles with start low
    snap = state_out;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("idle_busy", 320'(busy), 320'(0));
      chk("idle_done", 320'(done), 320'(0));
      chk("idle_state", state_out, snap);
    end

    chk("scoreboard_drained", 320'(exp_q.size()), 320'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ascon_round_ctrl.md
ASCON_ROUND_CTRL -- requirements
Module: ascon_round_ctrl

Interface
REQ-001 The block SHALL have no parameters; round counts are fixed at 12 (p^12) and 8 (p^8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a permutation; sampled only when idle.
REQ-005 nrounds  input  1  0 = 8 rounds, 1 = 12 rounds; sampled with start.
REQ-006 state_in  input  ascon_state  initial 320-bit state; sampled with start.
REQ-007 rnd  output  round  round index driven to the external round-function datapath.
REQ-008 round_out  output  ascon_state  current state register, fed to the round-function datapath.
REQ-009 round_in  input  ascon_state  combinational result of one full round (pc, ps, pl) applied to round_out with index rnd.
REQ-010 busy  output  1  high while rounds are executing.
REQ-011 done  output  1  one-cycle pulse: permutation result valid.
REQ-012 state_out  output  ascon_state  final state, valid from the done pulse until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE and RUN; IDLE -> RUN on start; RUN -> IDLE on the edge applying the last round.
REQ-014 start in IDLE at edge k: state register <= state_in; rnd <= 4'h4 if nrounds = 1, else 4'h8; FSM -> RUN.
REQ-015 Each RUN edge: state register <= round_in; rnd increments by 1.
REQ-016 The last round SHALL use rnd = 4'hF for both round counts; the counter SHALL NOT wrap to 4'h0 inside RUN.
REQ-017 p^12 SHALL apply rnd 4..F (12 updates, edges k+1..k+12); p^8 SHALL apply rnd 8..F (edges k+1..k+8).
REQ-018 Edge applying rnd = 4'hF: FSM -> IDLE, done <= 1, busy <= 0, rnd <= 4'h0.
REQ-019 Latency: done high in cycle following edge k+12 (p^12) or k+8 (p^8); throughput one permutation per 13 / 9 cycles.
REQ-020 busy SHALL be high exactly in the cycles in which FSM = RUN.
REQ-021 done SHALL be high for exactly one cycle per accepted start.
REQ-022 state_out SHALL equal the state register; the register SHALL hold in IDLE.
REQ-023 start while busy SHALL be ignored: no reload, no change to nrounds, rnd, or count.
REQ-024 start in the done cycle SHALL be accepted (back-to-back); done still pulses once for the prior operation, and state_out changes at the accepting edge.
REQ-025 rnd SHALL be 4'h0 whenever the FSM is IDLE.
REQ-026 nrounds and state_in SHALL be don't-care when start is low or the block is busy.

Reset
REQ-027 rst high at any edge SHALL force IDLE, busy = 0, done = 0, rnd = 4'h0, and the state register = 320'h0; rst takes priority over start.
REQ-028 Reset mid-RUN SHALL abandon the operation with no done pulse; start SHALL be accepted on the first edge with rst low.

Verification
REQ-029 p^12: start = 1, nrounds = 1, state_in = 320'h0 -> rnd sequence 4..F on 12 consecutive cycles; done 12 cycles after the accepting edge; state_out = golden-model p^12(0).
REQ-030 p^8: nrounds = 0, random state_in -> rnd sequence 8..F; done after 8 cycles; state_out = golden-model p^8(state_in).
REQ-031 start pulsed at rnd = 4'h9 during p^12 with different state_in -> ignored; result matches the original input; single done.
REQ-032 start asserted in the done cycle with nrounds toggled -> second operation starts immediately; two done pulses 13 then 9 cycles apart; both results correct.
REQ-033 rst asserted at rnd = 4'h7, together with start -> next cycle busy = 0, done = 0, rnd = 0, state_out = 0; no done pulse follows.
REQ-034 Idle with start low for 20 cycles -> busy, done, and rnd stay 0; state_out is stable.
